// File: rtl/bpred_pht_ctrl.sv
// Pattern history table controller: owns a 2^IDX_W x 2-bit counter array behind one port,
// arbitrating fetch lookups against queued retire updates applied as read-modify-write.
module bpred_pht_ctrl #(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  INIT_CTR = 2'b01,
    parameter int unsigned UQ_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_req_i,
    input  logic             lk_valid_i,
    input  logic [IDX_W-1:0] lk_idx_i,
    output logic             lk_ready_o,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [1:0]       pred_ctr_o,
    input  logic             up_valid_i,
    input  logic [IDX_W-1:0] up_idx_i,
    input  logic             up_taken_i,
    output logic             up_ready_o,
    output logic             busy_o
);

    localparam int unsigned Entries = 1 << IDX_W;
    localparam int unsigned PtrW    = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(UQ_DEPTH + 1);

    typedef enum logic {StInit, StRun} state_e;
    // The read phase is the pop cycle itself; the engine only registers the pending write.
    typedef enum logic {UIdle, UWr} ueng_e;

    state_e             state_q, state_d;
    ueng_e              ueng_q, ueng_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
    logic [1:0]         upd_ctr_q, upd_ctr_d;
    logic [PtrW-1:0]    wptr_q, wptr_d;
    logic [PtrW-1:0]    rptr_q, rptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               pred_valid_q, pred_valid_d;
    logic [1:0]         pred_ctr_q, pred_ctr_d;

    logic [1:0]         pht_q [Entries];
    logic [IDX_W-1:0]   uq_idx_q [UQ_DEPTH];
    logic               uq_tk_q [UQ_DEPTH];

    logic               run, q_full, q_empty;
    logic               lk_fire, push, u_rd, wr_upd;
    logic [IDX_W-1:0]   head_idx;
    logic               head_tk;
    logic [1:0]         head_ctr;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic tk);
        if (tk) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign run      = (state_q == StRun);
    assign q_full   = (cnt_q == CntW'(UQ_DEPTH));
    assign q_empty  = (cnt_q == '0);
    assign head_idx = uq_idx_q[rptr_q];
    assign head_tk  = uq_tk_q[rptr_q];
    assign head_ctr = pht_q[head_idx];

    assign up_ready_o = run && !init_req_i && !q_full;
    assign lk_ready_o = run && !init_req_i && (ueng_q != UWr) && !q_full;
    assign push       = up_valid_i && up_ready_o;
    assign lk_fire    = lk_valid_i && lk_ready_o;
    // A full queue steals the port from lookups; otherwise lookups win over draining.
    assign u_rd       = run && !init_req_i && (ueng_q == UIdle) && !q_empty
                        && (q_full || !lk_valid_i);
    assign wr_upd     = run && !init_req_i && (ueng_q == UWr);

    always_comb begin
        state_d      = state_q;
        ueng_d       = ueng_q;
        sweep_d      = sweep_q;
        upd_idx_d    = upd_idx_q;
        upd_ctr_d    = upd_ctr_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        pred_valid_d = lk_fire;
        pred_ctr_d   = lk_fire ? pht_q[lk_idx_i] : pred_ctr_q;

        if (init_req_i) begin
            state_d = StInit;
            sweep_d = '0;
            ueng_d  = UIdle;
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    sweep_d = sweep_q + IDX_W'(1);
                    if (sweep_q == '1) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (push) begin
                        wptr_d = wptr_q + PtrW'(1);
                    end
                    if (u_rd) begin
                        rptr_d = rptr_q + PtrW'(1);
                    end
                    cnt_d = cnt_q + CntW'(push) - CntW'(u_rd);
                    if (ueng_q == UWr) begin
                        ueng_d = UIdle;
                    end else if (u_rd) begin
                        ueng_d    = UWr;
                        upd_idx_d = head_idx;
                        upd_ctr_d = sat_ctr(head_ctr, head_tk);
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StInit;
            ueng_q       <= UIdle;
            sweep_q      <= '0;
            upd_idx_q    <= '0;
            upd_ctr_q    <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            state_q      <= state_d;
            ueng_q       <= ueng_d;
            sweep_q      <= sweep_d;
            upd_idx_q    <= upd_idx_d;
            upd_ctr_q    <= upd_ctr_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            pred_valid_q <= pred_valid_d;
            pred_ctr_q   <= pred_ctr_d;
        end
    end

    // Storage needs no reset: the sweep rewrites every entry before RUN.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (state_q == StInit) begin
                pht_q[sweep_q] <= INIT_CTR;
            end else if (wr_upd) begin
                pht_q[upd_idx_q] <= upd_ctr_q;
            end
            if (push) begin
                uq_idx_q[wptr_q] <= up_idx_i;
                uq_tk_q[wptr_q]  <= up_taken_i;
            end
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_ctr_o   = pred_ctr_q;
    assign pred_taken_o = pred_ctr_q[1];
    assign busy_o       = (state_q == StInit);

endmodule

// File: tb/tb_bpred_pht_ctrl.sv
// Directed bench for bpred_pht_ctrl; predictions checked against a scoreboard queue.
module tb_bpred_pht_ctrl;

    localparam int unsigned IDX_W = 6;

    logic             clk;
    logic             rst_n;
    logic             init_req;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic [1:0]       pred_ctr;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_taken;
    logic             up_ready;
    logic             busy;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] ref_tbl [64];
    logic [1:0] exp_v;

    bpred_pht_ctrl #(
        .IDX_W    (IDX_W),
        .INIT_CTR (2'b01),
        .UQ_DEPTH (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .init_req_i   (init_req),
        .lk_valid_i   (lk_valid),
        .lk_idx_i     (lk_idx),
        .lk_ready_o   (lk_ready),
        .pred_valid_o (pred_valid),
        .pred_taken_o (pred_taken),
        .pred_ctr_o   (pred_ctr),
        .up_valid_i   (up_valid),
        .up_idx_i     (up_idx),
        .up_taken_i   (up_taken),
        .up_ready_o   (up_ready),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] c, input logic tk);
        int v;
        v = int'(c) + (tk ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    // Prediction scoreboard
    always @(negedge clk) begin
        if (pred_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pred_unexpected", 32'(pred_valid), 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                chk("pred_ctr", 32'(pred_ctr), 32'(exp_v));
                chk("pred_taken", 32'(pred_taken), 32'(exp_v[1]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input int idx, input logic [1:0] exp, output int waits);
        waits = 0;
        lk_valid = 1'b1;
        lk_idx = IDX_W'(idx);
        @(negedge clk);
        while (lk_ready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        chk("lk_handshake", 32'(lk_ready), 32'd1);
        if (lk_ready === 1'b1) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
    endtask

    task automatic do_update(input int idx, input logic tk);
        int w;
        w = 0;
        up_valid = 1'b1;
        up_idx = IDX_W'(idx);
        up_taken = tk;
        @(negedge clk);
        while (up_ready !== 1'b1 && w < 50) begin
            w++;
            @(negedge clk);
        end
        chk("up_handshake", 32'(up_ready), 32'd1);
        if (up_ready === 1'b1) ref_tbl[idx] = nxt(ref_tbl[idx], tk);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    initial begin
        int n;
        int w;
        int acc;
        int lk_low;
        int first_ref;
        logic [1:0] old_v;

        rst_n = 1'b0;
        init_req = 1'b0;
        lk_valid = 1'b0;
        lk_idx = '0;
        up_valid = 1'b0;
        up_idx = '0;
        up_taken = 1'b0;
        for (int i = 0; i < 64; i++) ref_tbl[i] = 2'b01;

        idle(3);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_lk_ready", 32'(lk_ready), 32'd0);
        chk("rst_up_ready", 32'(up_ready), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_ctr", 32'(pred_ctr), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);

        rst_n = 1'b1;
        wait_busy(n);
        chk("init_busy_cycles", 32'(n), 32'd64);
        chk("run_lk_ready", 32'(lk_ready), 32'd1);
        chk("run_up_ready", 32'(up_ready), 32'd1);
        do_lookup(0, 2'b01, w);
        do_lookup(63, 2'b01, w);

        // Saturation in both directions on one entry
        repeat (2) do_update(5, 1'b1);
        idle(5);
        do_lookup(5, 2'b11, w);
        repeat (3) do_update(5, 1'b1);
        idle(5);
        do_lookup(5, 2'b11, w);
        repeat (4) do_update(5, 1'b0);
        idle(5);
        do_lookup(5, 2'b00, w);
        chk("ref_idx5", 32'(ref_tbl[5]), 32'd0);

        // Lookups every cycle with back-to-back updates competing for the port
        acc = 0;
        lk_low = 0;
        first_ref = -1;
        for (int c = 0; c < 12; c++) begin
            lk_valid = 1'b1;
            lk_idx = IDX_W'(10 + c);
            up_valid = (acc < 3);
            up_idx = IDX_W'(20 + acc);
            up_taken = 1'b1;
            @(negedge clk);
            if (lk_ready === 1'b1) exp_q.push_back(ref_tbl[10 + c]);
            else lk_low++;
            if (up_valid) begin
                if (up_ready === 1'b1) begin
                    ref_tbl[20 + acc] = nxt(ref_tbl[20 + acc], 1'b1);
                    acc++;
                end else if (first_ref < 0) begin
                    first_ref = acc;
                end
            end
            @(posedge clk);
            #1;
        end
        lk_valid = 1'b0;
        up_valid = 1'b0;
        chk("stream_updates_accepted", 32'(acc), 32'd3);
        chk("stream_up_ready_drop_at", 32'(first_ref), 32'd2);
        chk("stream_lk_stall_cycles", 32'(lk_low), 32'd4);
        idle(6);
        for (int i = 20; i < 23; i++) do_lookup(i, ref_tbl[i], w);

        // No bypass: lookup right after the update sees the old counter
        old_v = ref_tbl[30];
        do_update(30, 1'b1);
        do_lookup(30, old_v, w);
        chk("hazard_old_no_wait", 32'(w), 32'd0);
        idle(5);
        do_lookup(30, ref_tbl[30], w);
        // Lookup accepted three edges after the update sees the new counter
        do_update(31, 1'b1);
        idle(1);
        do_lookup(31, ref_tbl[31], w);
        chk("hazard_new_edge", 32'(w), 32'd1);
        chk("ref_idx31", 32'(ref_tbl[31]), 32'd2);
        idle(4);

        // init_req while the queue is full and the head update is being read
        for (int c = 0; c < 2; c++) begin
            lk_valid = 1'b1;
            lk_idx = IDX_W'(40);
            up_valid = 1'b1;
            up_idx = IDX_W'(41);
            up_taken = 1'b1;
            @(negedge clk);
            chk("fill_lk_ready", 32'(lk_ready), 32'd1);
            chk("fill_up_ready", 32'(up_ready), 32'd1);
            if (lk_ready === 1'b1) exp_q.push_back(ref_tbl[40]);
            @(posedge clk);
            #1;
        end
        init_req = 1'b1;
        @(negedge clk);
        chk("initreq_lk_ready", 32'(lk_ready), 32'd0);
        chk("initreq_up_ready", 32'(up_ready), 32'd0);
        @(posedge clk);
        #1;
        init_req = 1'b0;
        lk_valid = 1'b0;
        up_valid = 1'b0;
        for (int i = 0; i < 64; i++) ref_tbl[i] = 2'b01;
        wait_busy(n);
        chk("reinit_busy_cycles", 32'(n), 32'd64);
        for (int i = 0; i < 64; i++) begin
            lk_valid = 1'b1;
            lk_idx = IDX_W'(i);
            @(negedge clk);
            chk("scan_lk_ready", 32'(lk_ready), 32'd1);
            if (lk_ready === 1'b1) exp_q.push_back(ref_tbl[i]);
            @(posedge clk);
            #1;
        end
        lk_valid = 1'b0;
        idle(3);

        // Lookup presented in an otherwise quiet init_req cycle must not be accepted
        lk_valid = 1'b1;
        lk_idx = IDX_W'(0);
        init_req = 1'b1;
        @(negedge clk);
        chk("quiet_initreq_lk_ready", 32'(lk_ready), 32'd0);
        @(posedge clk);
        #1;
        lk_valid = 1'b0;
        init_req = 1'b0;
        wait_busy(n);
        chk("reinit2_busy_cycles", 32'(n), 32'd64);
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpred_pht_ctrl.md
# bpred_pht_ctrl

Controller for the branch predictor's pattern history table (PHT): a 2^IDX_W-entry array of 2-bit saturating counters behind a single access port. It shares that port between the fetch-side lookup requester and the retire-side update requester, and sequences every update as a read-modify-write. After reset or an explicit request it runs an init sweep that writes every entry. It sits between fetch/retire and the predictor storage, replacing per-branch 1-bit state with indexed 2-bit history.

## Interface
- IDX_W, 6, PHT index width; table has 2^IDX_W entries
- INIT_CTR, 2'b01, counter value written to every entry by the init sweep (weakly not-taken)
- UQ_DEPTH, 2, update queue depth (power of 2, >= 2)

- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- init_req  input  1  one-cycle pulse; restart the init sweep
- lk_valid  input  1  lookup request
- lk_idx  input  IDX_W  lookup index
- lk_ready  output  1  lookup accepted when lk_valid && lk_ready
- pred_valid  output  1  one-cycle pulse, prediction for accepted lookup
- pred_taken  output  1  predicted direction = counter bit 1
- pred_ctr  output  2  raw counter read
- up_valid  input  1  update request from retire
- up_idx  input  IDX_W  update index
- up_taken  input  1  resolved branch outcome
- up_ready  output  1  update accepted when up_valid && up_ready
- busy  output  1  init sweep in progress

## Operation
- FSM states: INIT, RUN. In RUN, the update engine has sub-phases U_IDLE, U_RD, U_WR.
- Reset (rst_n=0 at a clock edge): state=INIT, sweep pointer=0, queue emptied, update engine in U_IDLE. Outputs: pred_valid=0, pred_taken=0, pred_ctr=0, lk_ready=0, up_ready=0, busy=1.
- INIT: writes INIT_CTR to the entry at the pointer each cycle and increments the pointer. After writing entry 2^IDX_W-1 the FSM enters RUN. busy=1 throughout; lk_ready=0 and up_ready=0.
- init_req=1 in any state:
  - Next state is INIT with pointer=0.
  - Queue flushed; any in-flight update in U_RD or U_WR is aborted (no write).
  - lk_ready and up_ready are forced 0 in the init_req cycle, so no handshake occurs.
  - A pred_valid already due from the previous cycle is still delivered.
- Update queue: FIFO of {idx, taken}, UQ_DEPTH entries. up_ready = RUN && !init_req && count<UQ_DEPTH, where count is the registered value. A push and a pop may occur in the same cycle.
- Port arbitration, one access per cycle in RUN, in priority order:
  1. U_WR: write the updated counter. Port busy, so lk_ready=0.
  2. Queue full: pop the head, read the entry, go to U_RD. lk_ready=0.
  3. lk_valid: perform the lookup read. lk_ready=1.
  4. Queue non-empty: pop the head, read the entry, go to U_RD.
- lk_ready = RUN && !init_req && !U_WR && !full. It does not depend on lk_valid.
- U_RD: computes the next counter value, then goes to U_WR. U_WR writes the value, then goes to U_IDLE.
- Counter rule:
  - Taken: ctr = (ctr==3) ? 3 : ctr+1.
  - Not taken: ctr = (ctr==0) ? 0 : ctr-1.
  - 2-bit unsigned arithmetic, no wrap.
- Hazard: a lookup to an index with a queued or in-flight update returns the current table value (pre-update). This is architecturally allowed; there is no bypass.
- Updates are applied strictly in acceptance order. Two updates to the same index both take effect.

## Timing
- Init: rst_n high from edge 0 → entries written at edges 0..2^IDX_W-1; busy=0 and ready outputs valid from cycle 2^IDX_W (64 with default IDX_W).
- Lookup accepted at edge N → pred_valid=1 with pred_taken/pred_ctr during cycle N+1.
  - pred_valid returns to 0 unless another lookup was accepted at N+1.
  - pred_taken/pred_ctr hold their last value when pred_valid=0.
- Update accepted at edge N with an empty queue and no competing lookup:
  - Read at N+1 (U_RD), write at N+2 (U_WR).
  - The earliest lookup that sees the new value is accepted at N+3.
- Continuous lookups: updates wait until the queue is full, then steal 2 consecutive slots (read + write). Worst-case lookup stall is 2 cycles per update.
- Reset mid-sweep or mid-update: same as power-on reset; the full sweep is repeated.

## Test plan
- Reset, then hold rst_n=1 with idle inputs → busy=1 for 64 cycles, then 0; lookup idx 0 and idx 63 → pred_ctr=01, pred_taken=0.
- Two up_taken=1 updates to idx 5, then lookup idx 5 → pred_ctr=11, pred_taken=1.
- Three further taken updates to idx 5 → ctr stays 11.
- Four not-taken updates to idx 5 → ctr=00.
- lk_valid held high every cycle plus 3 back-to-back updates:
  - up_ready drops at count=2.
  - lk_ready drops for exactly 2 cycles per forced update.
  - No update is lost; final counters match the reference model.
- Update accepted at edge N, lookup to the same idx accepted at N+1 → returns the old value. Lookup accepted at N+3 → returns the new value.
- init_req pulsed while the queue holds 2 entries and an update is in U_RD:
  - No write from the aborted update.
  - busy=1 for 64 cycles.
  - Afterwards all entries read 01.
  - No pred_valid for a lookup presented in the init_req cycle.
